// File: rtl/ysyx_041514_mul_pkg.sv
// rtl/ysyx_041514_mul_pkg.sv - shared types and helpers for the radix-4 Booth multiplier
//
// Contents:
//   mul_state_e   : controller state (IDLE / BUSY / DONE)
//   booth_sel_e   : partial-product selection (ZERO, +A, +2A, -A, -2A)
//   mul_iters()   : number of Booth digits for a given operand width
//   booth_decode(): maps a multiplier bit triplet to its selection

package ysyx_041514_mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mul_state_e;

    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_POS1 = 3'd1,
        SEL_POS2 = 3'd2,
        SEL_NEG1 = 3'd3,
        SEL_NEG2 = 3'd4
    } booth_sel_e;

    // Operands are extended to WIDTH+2 bits, so WIDTH/2+1 digits cover every
    // multiplier bit including the extension.
    function automatic int mul_iters(input int width);
        return width / 2 + 1;
    endfunction

    // Triplet is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_sel_e booth_decode(input logic [2:0] triplet);
        booth_sel_e sel;
        case (triplet)
            3'b001, 3'b010: sel = SEL_POS1;
            3'b011:         sel = SEL_POS2;
            3'b100:         sel = SEL_NEG2;
            3'b101, 3'b110: sel = SEL_NEG1;
            default:        sel = SEL_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ysyx_041514_booth_sel.sv
// rtl/ysyx_041514_booth_sel.sv - combinational radix-4 Booth partial-product select
//
// Parameters:
//   XW         : multiplicand width (WIDTH+2 for a bare extended multiplicand)
// Ports:
//   triplet_i  : {b[2i+1], b[2i], b[2i-1]} of the multiplier
//   x_i        : two's complement multiplicand
//   pp_o       : XW+1 bit partial product; for negative selections this is
//                the bitwise inverse of the magnitude
//   neg_o      : 1 when pp_o is inverted; the accumulator adds it as carry-in
//                to complete the two's complement negation

module ysyx_041514_booth_sel
    import ysyx_041514_mul_pkg::*;
#(
    parameter int XW = 66
) (
    input  logic [2:0]  triplet_i,
    input  logic [XW-1:0] x_i,
    output logic [XW:0]   pp_o,
    output logic          neg_o
);

    booth_sel_e sel;

    assign sel = booth_decode(triplet_i);

    always_comb begin
        pp_o  = '0;
        neg_o = 1'b0;
        case (sel)
            SEL_POS1: pp_o = {x_i[XW-1], x_i};
            SEL_POS2: pp_o = {x_i, 1'b0};
            SEL_NEG1: begin
                pp_o  = ~{x_i[XW-1], x_i};
                neg_o = 1'b1;
            end
            SEL_NEG2: begin
                pp_o  = ~{x_i, 1'b0};
                neg_o = 1'b1;
            end
            default: pp_o = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_041514_alu_mul_booth.sv
// rtl/ysyx_041514_alu_mul_booth.sv - iterative radix-4 Booth multiplier, one digit per cycle
//
// Parameters:
//   WIDTH               : operand width (even, >= 4); product is 2*WIDTH bits
// Ports:
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   flush_i             : synchronous abort of any in-flight or held operation
//   rs1/rs2_signed_valid_i : per-operand signedness (1 = two's complement)
//   rs1_data_i          : multiplicand
//   rs2_data_i          : multiplier
//   mul_valid_i / mul_ready_o         : request handshake
//   mul_out_valid_o / mul_out_ready_i : result handshake
//   mul_out_o           : product, stable while mul_out_valid_o is high
// Configuration:
//   MUL_EARLY_OUT_EN    : when defined, finish as soon as every remaining
//                         multiplier bit (guard included) is identical

module ysyx_041514_alu_mul_booth
    import ysyx_041514_mul_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               rs1_signed_valid_i,
    input  logic               rs2_signed_valid_i,
    input  logic [WIDTH-1:0]   rs1_data_i,
    input  logic [WIDTH-1:0]   rs2_data_i,
    input  logic               mul_valid_i,
    output logic               mul_ready_o,
    output logic               mul_out_valid_o,
    input  logic               mul_out_ready_i,
    output logic [2*WIDTH-1:0] mul_out_o
);

    localparam int N  = mul_iters(WIDTH);
    localparam int PW = 2 * WIDTH;
    localparam int BW = WIDTH + 3;     // extended multiplier plus guard bit
    localparam int CW = $clog2(N + 1);

    mul_state_e     state_q, state_d;
    logic [PW-1:0]  mcand_q, mcand_d;
    logic [BW-1:0]  mplr_q, mplr_d;
    logic [PW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           out_valid_q, out_valid_d;

    logic [WIDTH+1:0] rs1_ext, rs2_ext;
    logic [PW:0]      pp;
    logic             pp_neg;
    logic [PW-1:0]    acc_sum;
    logic [BW-1:0]    mplr_shift;
    logic             early_done;
    logic             unused_pp_msb;

    assign rs1_ext = {{2{rs1_signed_valid_i & rs1_data_i[WIDTH-1]}}, rs1_data_i};
    assign rs2_ext = {{2{rs2_signed_valid_i & rs2_data_i[WIDTH-1]}}, rs2_data_i};

    // The multiplicand register already carries the 2i weight, so the select
    // unit works at full product width and the sum wraps modulo 2^(2*WIDTH).
    ysyx_041514_booth_sel #(
        .XW (PW)
    ) u_booth_sel (
        .triplet_i (mplr_q[2:0]),
        .x_i       (mcand_q),
        .pp_o      (pp),
        .neg_o     (pp_neg)
    );

    assign unused_pp_msb = pp[PW];
    assign acc_sum       = acc_q + pp[PW-1:0] + {{(PW-1){1'b0}}, pp_neg};

    // Arithmetic shift keeps the sign fill so the upper digits stay valid.
    assign mplr_shift = {{2{mplr_q[BW-1]}}, mplr_q[BW-1:2]};

`ifdef MUL_EARLY_OUT_EN
    // Uniform remaining bits decode to ZERO digits from here on.
    assign early_done = (mplr_shift == '0) || (&mplr_shift);
`else
    assign early_done = 1'b0;
`endif

    assign mul_ready_o     = (state_q == S_IDLE);
    assign mul_out_valid_o = out_valid_q;
    assign mul_out_o       = acc_q;

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplr_d      = mplr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (mul_valid_i) begin
                    state_d = S_BUSY;
                    mcand_d = {{(PW-WIDTH-2){rs1_ext[WIDTH+1]}}, rs1_ext};
                    mplr_d  = {rs2_ext, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << 2;
                mplr_d  = mplr_shift;
                cnt_d   = cnt_q + 1'b1;
                if ((cnt_q == CW'(N - 1)) || early_done) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (mul_out_ready_i) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Pipeline kill wins over both acceptance and handoff.
        if (flush_i) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplr_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplr_q      <= mplr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_ysyx_041514_alu_mul_booth.sv
// tb/tb_ysyx_041514_alu_mul_booth.sv - self-checking bench for the radix-4 Booth multiplier

module tb_ysyx_041514_alu_mul_booth;

    localparam int W = 64;
    localparam int N = W / 2 + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush_i = 1'b0;
    logic           rs1_s = 1'b0;
    logic           rs2_s = 1'b0;
    logic [W-1:0]   rs1_data = '0;
    logic [W-1:0]   rs2_data = '0;
    logic           mul_valid = 1'b0;
    logic           mul_ready;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] mul_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_041514_alu_mul_booth #(.WIDTH(W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush_i            (flush_i),
        .rs1_signed_valid_i (rs1_s),
        .rs2_signed_valid_i (rs2_s),
        .rs1_data_i         (rs1_data),
        .rs2_data_i         (rs2_data),
        .mul_valid_i        (mul_valid),
        .mul_ready_o        (mul_ready),
        .mul_out_valid_o    (out_valid),
        .mul_out_ready_i    (out_ready),
        .mul_out_o          (mul_out)
    );

    task automatic check(input string nm, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Exact product of the interpreted operands, wrapped to 2*W bits.
    function automatic logic [2*W-1:0] ref_mul(input bit s1, input bit s2,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W+1:0] ea, eb, p;
        ea = s1 ? {{(W+2){a[W-1]}}, a} : {{(W+2){1'b0}}, a};
        eb = s2 ? {{(W+2){b[W-1]}}, b} : {{(W+2){1'b0}}, b};
        p  = ea * eb;
        return p[2*W-1:0];
    endfunction

    // Cycles from acceptance to result valid.
    function automatic int lat_of(input bit s2, input logic [W-1:0] b);
`ifdef MUL_EARLY_OUT_EN
        logic signed [W+2:0] m;
        m = {(s2 ? {2{b[W-1]}} : 2'b00), b, 1'b0};
        for (int k = 1; k <= N; k++) begin
            m = m >>> 2;
            if (m == 0 || m == -1) return k;
        end
        return N;
`else
        return N;
`endif
    endfunction

    // Transaction-level model: 0 idle, 1 computing, 2 holding result.
    int             m_state;
    int             m_cnt;
    logic [2*W-1:0] m_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_cnt   <= 0;
            m_prod  <= '0;
        end else if (flush_i) begin
            m_state <= 0;
        end else begin
            case (m_state)
                0: if (mul_valid) begin
                    m_state <= 1;
                    m_cnt   <= lat_of(rs2_s, rs2_data);
                    m_prod  <= ref_mul(rs1_s, rs2_s, rs1_data, rs2_data);
                end
                1: if (m_cnt <= 1) m_state <= 2; else m_cnt <= m_cnt - 1;
                default: if (out_ready) m_state <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("ready", {127'd0, mul_ready}, {127'd0, m_state == 0});
            check("out_valid", {127'd0, out_valid}, {127'd0, m_state == 2});
            if (m_state == 2) check("product", mul_out, m_prod);
        end
    end

    // Present one request, wait for the result, hold it for `hold` cycles,
    // then hand it off. Starts and ends 2 time units after a rising edge.
    task automatic run_op(input string nm, input bit s1, input bit s2,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input logic [2*W-1:0] exp);
        int  lat;
        bit  got_ready;
        rs1_s = s1; rs2_s = s2; rs1_data = a; rs2_data = b; mul_valid = 1'b1;
        got_ready = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mul_ready) begin got_ready = 1'b1; break; end
        end
        check({nm, "_accept"}, {127'd0, got_ready}, {127'd0, 1'b1});
        @(posedge clk); #2;
        mul_valid = 1'b0;
        rs1_data = {$urandom, $urandom};
        rs2_data = {$urandom, $urandom};
        rs1_s = 1'($urandom); rs2_s = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
        end while (!out_valid && lat < 200);
        check({nm, "_latency"}, 128'(lat), 128'(lat_of(s2, b)));
        check({nm, "_result"}, mul_out, exp);
        repeat (hold) @(posedge clk);
        #2 out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int lat;

        // Reset state.
        @(negedge clk);
        check("reset_ready", {127'd0, mul_ready}, {127'd0, 1'b1});
        check("reset_valid", {127'd0, out_valid}, 128'd0);
        check("reset_out", mul_out, 128'd0);
        mul_valid = 1'b1;    // ignored while in reset
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1; mul_valid = 1'b0;
        @(negedge clk);
        check("post_reset_out", mul_out, 128'd0);
        @(posedge clk); #2;

        // Signed -1 * -1, with a literal latency pin in the default build.
        run_op("neg1_sq", 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 128'd1);
`ifndef MUL_EARLY_OUT_EN
        check("lat_model_pin", 128'(lat_of(1'b1, 64'hFFFF_FFFF_FFFF_FFFF)), 128'd33);
`endif
        // Unsigned max squared, with 10 cycles of backpressure.
        run_op("umax_sq", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 10,
               128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        run_op("mixed_min", 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0,
               128'h8000_0000_0000_0000_8000_0000_0000_0000);
        run_op("smax_smin", 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2,
               128'hC000_0000_0000_0000_8000_0000_0000_0000);
        run_op("neg5_x2", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd2, 0,
               128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF6);
        run_op("zero", 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'd0, 0, 128'd0);
        check("model_pin_21", ref_mul(1'b0, 1'b0, 64'd3, 64'd7), 128'd21);

        // Flush on the fifth BUSY cycle: idle next cycle, no result pulse.
        rs1_s = 1'b0; rs2_s = 1'b0; rs1_data = 64'd11; rs2_data = 64'd13; mul_valid = 1'b1;
        @(posedge clk); #2 mul_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 flush_i = 1'b1;
        @(posedge clk); #2 flush_i = 1'b0;
        check("flush_ready", {127'd0, mul_ready}, {127'd0, 1'b1});
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("flush_no_pulse", 128'(cnt), 128'd0);
        @(posedge clk); #2;
        run_op("three_x7", 1'b0, 1'b0, 64'd3, 64'd7, 0, 128'd21);

        // Request held high across an operation and consumer always ready:
        // back-to-back operations, each N+2 cycles apart.
        rs1_s = 1'b0; rs2_s = 1'b0; rs1_data = 64'd3; rs2_data = 64'd7;
        mul_valid = 1'b1; out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3 * (N + 2); i++) begin
            @(negedge clk);
            if (out_valid && out_ready) cnt++;
            @(posedge clk); #2;
        end
`ifndef MUL_EARLY_OUT_EN
        check("b2b_handoffs", 128'(cnt), 128'd3);
`endif
        mul_valid = 1'b0;
        lat = 0;
        while (!mul_ready && lat < 100) begin
            @(posedge clk); #2; lat++;
        end
        out_ready = 1'b0;

        // Asynchronous reset mid-operation: abandoned with no output pulse.
        rs1_data = 64'd5; rs2_data = 64'd9; mul_valid = 1'b1;
        @(posedge clk); #2 mul_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_ready", {127'd0, mul_ready}, {127'd0, 1'b1});
        check("async_rst_valid", {127'd0, out_valid}, 128'd0);
        check("async_rst_out", mul_out, 128'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Random sweep against the model.
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] a, b;
            bit s1, s2;
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            s1 = 1'($urandom_range(0, 1));
            s2 = 1'($urandom_range(0, 1));
            run_op("random", s1, s2, a, b, int'($urandom_range(0, 3)), ref_mul(s1, s2, a, b));
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_041514_alu_mul_booth.md
# ysyx_041514_alu_mul_booth

Parametrised iterative radix-4 Booth multiplier for the ALU execute stage, replacing the fixed 64-bit slow multiplier. It computes the full 2*WIDTH-bit product of two WIDTH-bit operands, each independently signed or unsigned, retiring one Booth digit per cycle. It uses a valid/ready handshake on both the request and result sides, supports a synchronous flush for pipeline kill, and can optionally terminate early.

## Interface
- WIDTH, 64, operand width; even, ≥ 4
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous abort of any in-flight or held operation
- rs1_signed_valid_i  in  1  1 = rs1 is two's complement, 0 = unsigned
- rs2_signed_valid_i  in  1  1 = rs2 is two's complement, 0 = unsigned
- rs1_data_i  in  WIDTH  multiplicand
- rs2_data_i  in  WIDTH  multiplier
- mul_valid_i  in  1  request valid
- mul_ready_o  out  1  block can accept a request
- mul_out_valid_o  out  1  result valid
- mul_out_ready_i  in  1  consumer accepts result
- mul_out_o  out  2*WIDTH  product

## Operation
- States:
  - IDLE: mul_ready_o=1.
  - BUSY: one Booth digit consumed per cycle.
  - DONE: mul_out_valid_o=1, result held.
- IDLE→BUSY on mul_valid_i & mul_ready_o. Capture both operands and both sign flags at this edge; inputs are don't-care afterwards.
- Operand extension to WIDTH+2 bits: sign-extend if the flag is set, else zero-extend. Append a 0 guard bit below the multiplier LSB.
- Iteration count N = WIDTH/2+1.
- Iteration i examines the triplet {b[2i+1], b[2i], b[2i-1]} and selects 0, +A, +2A, −A or −2A. The selection is shifted by 2i and added to a 2*WIDTH-bit accumulator (modulo 2^(2*WIDTH)).
- Implementation: shift the multiplicand left by 2 and the multiplier right by 2 each cycle; an iteration counter tracks progress.
- BUSY→DONE after the last iteration. DONE→IDLE on mul_out_valid_o & mul_out_ready_i.
- mul_out_o is stable while mul_out_valid_o=1.
- No request is accepted in BUSY or DONE. A back-to-back request is accepted at the earliest one cycle after result handoff.
- flush_i: from any state, go to IDLE at the next edge and drop mul_out_valid_o. flush_i has priority over acceptance and over result handoff in the same cycle.
- The result equals the mathematically exact product of the interpreted operands; it always fits in 2*WIDTH bits.

## Timing
- Reset values:
  - state = IDLE
  - mul_ready_o = 1 (requests are ignored while rst_n=0)
  - mul_out_valid_o = 0
  - mul_out_o = 0
  - accumulator and counter = 0
- Reset mid-operation: the operation is abandoned immediately, with no output pulse.
- Latency: acceptance at edge E0 → mul_out_valid_o high after edge E0+N (33 cycles for WIDTH=64), or after E0+k with early-out.
- mul_ready_o is combinational from state only; no combinational path from inputs to outputs.
- mul_out_ready_i held low: the result is held indefinitely.

## Configuration
- MUL_EARLY_OUT_EN defined:
  - After each iteration, if all remaining multiplier bits, including the guard bit, are identical (all 0 or all 1), every later digit is 0, so go to DONE.
  - The first iteration always executes, giving latency k with 1 ≤ k ≤ N.
- Not defined: latency is always exactly N. The early-out compare logic is absent.

## Structure
- Package ysyx_041514_mul_pkg:
  - state enum (IDLE/BUSY/DONE)
  - Booth select encoding (ZERO, POS1, POS2, NEG1, NEG2)
  - constant function returning N for WIDTH
- Sub-module ysyx_041514_booth_sel, combinational: inputs are the triplet and the extended multiplicand; output is the WIDTH+3-bit partial product. Negation is done as invert plus carry-in into the accumulator adder.

## Test plan
- WIDTH=64, both signed, rs1=rs2=0xFFFF_FFFF_FFFF_FFFF → mul_out_o=1, valid 33 cycles after acceptance (early-out off).
- Both unsigned, rs1=rs2=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- rs1 signed 0x8000_0000_0000_0000, rs2 unsigned 0xFFFF_FFFF_FFFF_FFFF → 0x8000_0000_0000_0000_8000_0000_0000_0000 (= −2^63·(2^64−1)).
- Backpressure: mul_out_ready_i=0 for 10 cycles after valid. Result stays stable, mul_ready_o=0 throughout. Handoff on the ready edge, then IDLE.
- flush_i pulsed on BUSY cycle 5: IDLE next cycle, no mul_out_valid_o pulse. Then 3 × 7 completes correctly (=21).
- MUL_EARLY_OUT_EN: rs2=0 → valid 1 cycle after acceptance; rs2=3 unsigned → valid 2 cycles after. Random signed/unsigned sweep (WIDTH=64 and WIDTH=16) matches the reference product every time.
